i2c_target_regfile: RTL

- Synthesizable I2C target (responder) on the same I2C bus that the iicmb master drives.
- Oversamples SCL/SDA on the system clock and decodes START, repeated START and STOP.
- Matches a fixed 7-bit address, ACKs it, and serves a byte-addressed register file with an auto-incrementing pointer.
- Replaces the behavioural I2C slave BFM for gate-level and FPGA bring-up; exposes write-event outputs for scoreboarding.

---
 rtl/i2c_target_pkg.sv | 44 ++++
 rtl/i2c_bus_sync.sv | 50 +++++
 rtl/i2c_target_regfile.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_target_pkg.sv
`default_nettype none
// ============================================================================
// Module   : i2c_target_pkg
// Desc     : Shared types and constants for the I2C register-file target.
// Revision : 1.0 - initial release
// ============================================================================
package i2c_target_pkg;

    localparam logic [6:0] c_DEFAULT_TARGET_ADDR = 7'h22;

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        ADDR     = 4'd1,
        ADDR_ACK = 4'd2,
        WR_PTR   = 4'd3,
        WR_DATA  = 4'd4,
        WR_ACK   = 4'd5,
        RD_DATA  = 4'd6,
        RD_ACK   = 4'd7,
        IGNORE   = 4'd8
    } state_t;

    typedef enum logic [2:0] {
        NONE  = 3'd0,
        START = 3'd1,
        STOP  = 3'd2,
        RISE  = 3'd3,
        FALL  = 3'd4
    } bus_evt_t;

    // START/STOP need SCL high on both samples, so they never coincide with an SCL edge.
    function automatic bus_evt_t bus_event(input logic start_det, input logic stop_det,
                                           input logic scl_rise, input logic scl_fall);
        bus_evt_t evt;
        evt = NONE;
        if (start_det)     evt = START;
        else if (stop_det) evt = STOP;
        else if (scl_rise) evt = RISE;
        else if (scl_fall) evt = FALL;
        return evt;
    endfunction

endpackage
`default_nettype wire

// File: rtl/i2c_bus_sync.sv
`default_nettype none
// ============================================================================
// Module   : i2c_bus_sync
// Desc     : Two-flop SCL/SDA synchronizers with edge history and bus-event decode.
// Revision : 1.0 - initial release
// ============================================================================
module i2c_bus_sync (
    input  logic clk_i,
    input  logic rst_i,
    input  logic scl_i,
    input  logic sda_i,
    output logic start_det,
    output logic stop_det,
    output logic scl_rise,
    output logic scl_fall,
    output logic sda
);

    logic [1:0] r_scl_sync;
    logic [1:0] r_sda_sync;
    logic       r_scl_prev;
    logic       r_sda_prev;
    logic       w_scl;
    logic       w_sda;

    // Lines idle high, so resetting to 1 cannot fabricate an edge on an idle bus.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_scl_sync <= 2'b11;
            r_sda_sync <= 2'b11;
            r_scl_prev <= 1'b1;
            r_sda_prev <= 1'b1;
        end else begin
            r_scl_sync <= {r_scl_sync[0], scl_i};
            r_sda_sync <= {r_sda_sync[0], sda_i};
            r_scl_prev <= r_scl_sync[1];
            r_sda_prev <= r_sda_sync[1];
        end
    end

    assign w_scl     = r_scl_sync[1];
    assign w_sda     = r_sda_sync[1];
    assign start_det = w_scl & r_scl_prev & r_sda_prev & ~w_sda;
    assign stop_det  = w_scl & r_scl_prev & ~r_sda_prev & w_sda;
    assign scl_rise  = w_scl & ~r_scl_prev;
    assign scl_fall  = ~w_scl & r_scl_prev;
    assign sda       = w_sda;

endmodule
`default_nettype wire

// File: rtl/i2c_target_regfile.sv
`default_nettype none
// ============================================================================
// Module   : i2c_target_regfile
// Desc     : I2C target serving a byte-addressed register file with auto-increment.
// Revision : 1.0 - initial release
// ============================================================================
module i2c_target_regfile
    import i2c_target_pkg::*;
#(
    parameter int                        I2C_ADDR_WIDTH = 7,
    parameter int                        I2C_DATA_WIDTH = 8,
    parameter logic [I2C_ADDR_WIDTH-1:0] TARGET_ADDR    = c_DEFAULT_TARGET_ADDR,
    parameter int                        NUM_REGS       = 16
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        scl_i,
    input  logic                        sda_i,
    output logic                        scl_o,
    output logic                        sda_o,
    output logic                        busy_o,
    output logic                        reg_wr_o,
    output logic [$clog2(NUM_REGS)-1:0] reg_idx_o,
    output logic [I2C_DATA_WIDTH-1:0]   reg_wdata_o,
    output logic                        stop_o
);

    localparam int                 c_PTR_W    = $clog2(NUM_REGS);
    localparam int                 c_CNT_W    = $clog2(I2C_DATA_WIDTH + 2);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
    localparam logic [c_CNT_W-1:0] c_LAST_BIT = c_CNT_W'(I2C_DATA_WIDTH - 1);
    localparam logic [c_CNT_W-1:0] c_ACK_BIT  = c_CNT_W'(I2C_DATA_WIDTH);
    localparam logic [c_CNT_W-1:0] c_ACK_DONE = c_CNT_W'(I2C_DATA_WIDTH + 1);
    localparam logic [c_PTR_W-1:0] c_PTR_ONE  = c_PTR_W'(1);

    logic w_start;
    logic w_stop;
    logic w_rise;
    logic w_fall;
    logic w_sda;
    bus_evt_t w_evt;

    state_t                    r_state, w_state_nxt;
    logic [c_CNT_W-1:0]        r_bit_cnt, w_bit_cnt_nxt;
    logic [I2C_DATA_WIDTH-1:0] r_shift, w_shift_nxt;
    logic [c_PTR_W-1:0]        r_ptr, w_ptr_nxt;
    logic                      r_sda_drv, w_sda_drv_nxt;
    logic                      r_busy, w_busy_nxt;
    logic                      r_rw, w_rw_nxt;
    logic                      w_commit;
    logic                      w_stop_pulse;
    logic                      r_reg_wr;
    logic                      r_stop;
    logic [c_PTR_W-1:0]        r_reg_idx;
    logic [I2C_DATA_WIDTH-1:0] r_reg_wdata;
    logic [I2C_DATA_WIDTH-1:0] r_regs [NUM_REGS];
    logic [I2C_DATA_WIDTH-1:0] w_byte;
    logic [I2C_DATA_WIDTH-1:0] w_rd_byte;

    i2c_bus_sync u_bus_sync (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .scl_i     (scl_i),
        .sda_i     (sda_i),
        .start_det (w_start),
        .stop_det  (w_stop),
        .scl_rise  (w_rise),
        .scl_fall  (w_fall),
        .sda       (w_sda)
    );

    assign w_evt     = bus_event(w_start, w_stop, w_rise, w_fall);
    assign w_byte    = {r_shift[I2C_DATA_WIDTH-2:0], w_sda};
    assign w_rd_byte = r_regs[r_ptr];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= IDLE;
            r_bit_cnt   <= '0;
            r_shift     <= '0;
            r_ptr       <= '0;
            r_sda_drv   <= 1'b1;
            r_busy      <= 1'b0;
            r_rw        <= 1'b0;
            r_reg_wr    <= 1'b0;
            r_stop      <= 1'b0;
            r_reg_idx   <= '0;
            r_reg_wdata <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_bit_cnt <= w_bit_cnt_nxt;
            r_shift   <= w_shift_nxt;
            r_ptr     <= w_ptr_nxt;
            r_sda_drv <= w_sda_drv_nxt;
            r_busy    <= w_busy_nxt;
            r_rw      <= w_rw_nxt;
            r_reg_wr  <= w_commit;
            r_stop    <= w_stop_pulse;
            if (w_commit) begin
                r_reg_idx   <= r_ptr;
                r_reg_wdata <= w_byte;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
        end else if (w_commit) begin
            r_regs[r_ptr] <= w_byte;
        end
    end

    // Bit counter reaches c_ACK_BIT after the 8th rise and c_ACK_DONE after the 9th;
    // SDA only changes on falls so it is stable whenever SCL is high.
    always_comb begin
        w_state_nxt   = r_state;
        w_bit_cnt_nxt = r_bit_cnt;
        w_shift_nxt   = r_shift;
        w_ptr_nxt     = r_ptr;
        w_sda_drv_nxt = r_sda_drv;
        w_busy_nxt    = r_busy;
        w_rw_nxt      = r_rw;
        w_commit      = 1'b0;
        w_stop_pulse  = 1'b0;

        case (w_evt)
            START: begin
                w_state_nxt   = ADDR;
                w_bit_cnt_nxt = '0;
                w_sda_drv_nxt = 1'b1;
            end
            STOP: begin
                w_state_nxt   = IDLE;
                w_bit_cnt_nxt = '0;
                w_sda_drv_nxt = 1'b1;
                w_busy_nxt    = 1'b0;
                w_stop_pulse  = 1'b1;
            end
            RISE: begin
                case (r_state)
                    ADDR: begin
                        w_shift_nxt   = w_byte;
                        w_bit_cnt_nxt = r_bit_cnt + c_CNT_ONE;
                        if (r_bit_cnt == c_LAST_BIT) begin
                            if (r_shift[I2C_ADDR_WIDTH-1:0] == TARGET_ADDR) begin
                                w_state_nxt = ADDR_ACK;
                                w_busy_nxt  = 1'b1;
                                w_rw_nxt    = w_sda;
                            end else begin
                                w_state_nxt = IGNORE;
                            end
                        end
                    end
                    WR_PTR: begin
                        w_shift_nxt   = w_byte;
                        w_bit_cnt_nxt = r_bit_cnt + c_CNT_ONE;
                        if (r_bit_cnt == c_LAST_BIT) begin
                            w_ptr_nxt   = w_byte[c_PTR_W-1:0];
                            w_state_nxt = WR_ACK;
                        end
                    end
                    WR_DATA: begin
                        w_shift_nxt   = w_byte;
                        w_bit_cnt_nxt = r_bit_cnt + c_CNT_ONE;
                        if (r_bit_cnt == c_LAST_BIT) begin
                            w_commit    = 1'b1;
                            w_ptr_nxt   = r_ptr + c_PTR_ONE;
                            w_state_nxt = WR_ACK;
                        end
                    end
                    ADDR_ACK, WR_ACK: w_bit_cnt_nxt = c_ACK_DONE;
                    RD_DATA:          w_bit_cnt_nxt = r_bit_cnt + c_CNT_ONE;
                    RD_ACK: begin
                        if (!w_sda) begin
                            w_shift_nxt   = w_rd_byte;
                            w_bit_cnt_nxt = '0;
                            w_state_nxt   = RD_DATA;
                        end else begin
                            w_state_nxt = IGNORE;
                        end
                    end
                    default: ;
                endcase
            end
            FALL: begin
                case (r_state)
                    ADDR_ACK, WR_ACK: begin
                        if (r_bit_cnt == c_ACK_BIT) begin
                            w_sda_drv_nxt = 1'b0;
                        end else if (r_bit_cnt == c_ACK_DONE) begin
                            w_bit_cnt_nxt = '0;
                            if (r_state == ADDR_ACK && r_rw) begin
                                // First read bit must be on the bus before the next rise.
                                w_sda_drv_nxt = w_rd_byte[I2C_DATA_WIDTH-1];
                                w_shift_nxt   = {w_rd_byte[I2C_DATA_WIDTH-2:0], 1'b0};
                                w_state_nxt   = RD_DATA;
                            end else begin
                                w_sda_drv_nxt = 1'b1;
                                w_state_nxt   = (r_state == ADDR_ACK) ? WR_PTR : WR_DATA;
                            end
                        end
                    end
                    RD_DATA: begin
                        if (r_bit_cnt == c_ACK_BIT) begin
                            w_sda_drv_nxt = 1'b1;
                            w_ptr_nxt     = r_ptr + c_PTR_ONE;
                            w_state_nxt   = RD_ACK;
                        end else begin
                            w_sda_drv_nxt = r_shift[I2C_DATA_WIDTH-1];
                            w_shift_nxt   = {r_shift[I2C_DATA_WIDTH-2:0], 1'b0};
                        end
                    end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

    assign scl_o       = 1'b1;
    assign sda_o       = r_sda_drv;
    assign busy_o      = r_busy;
    assign reg_wr_o    = r_reg_wr;
    assign reg_idx_o   = r_reg_idx;
    assign reg_wdata_o = r_reg_wdata;
    assign stop_o      = r_stop;

endmodule
`default_nettype wire
